multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Control state machine for the multi-cycle MIPS datapath. Each cycle it decodes the latched opcode/funct and the current state into the datapath's mux selects, write strobes and ALU operation, walking each instruction through fetch, decode, execute, memory and write-back. It stalls on a memory-ready handshake and traps on unsupported encodings. It also keeps a retired-instruction counter for the testbench.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0].
- `isZero`  in  1  ALU zero flag (combinational from the datapath).
- `memReady`  in  1  unified memory completes the current access this cycle.
- `pcEn`  out  1  PC load = pcWrite | (branch & isZero).
- `iorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memRead`, `memWrite`  out  1 each  memory strobes, held until `memReady`.
- `irWrite`  out  1  latch instruction register.
- `regDst`  out  1  write register select: 1 = rd, 0 = rt.
- `memToReg`  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- `regWrite`  out  1  register file write enable.
- `aluSrcA`  out  1  0 = PC, 1 = A register.
- `aluSrcB`  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `aluOp`  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- `pcSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state`  out  4  current state encoding (debug).
- `halted`  out  1  trap state reached.
- `retired`  out  RETIRE_W  count of completed instructions.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, TRAP 12. Codes 13–15 are unreachable and go to TRAP.
- FETCH:
  - Outputs: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=add, pcSource=00.
  - irWrite and pcWrite are asserted only in a cycle where memReady=1.
  - Stay in FETCH while memReady=0; go to DECODE when memReady=1.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=add (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC
  - 100011 (lw) and 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - any other opcode → TRAP
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=add. lw → MEMRD, sw → MEMWR.
- MEMRD: memRead=1, iorD=1. Hold until memReady, then go to MEMWB.
- MEMWB: regWrite=1, regDst=0, memToReg=1. Retire; go to FETCH.
- MEMWR: memWrite=1, iorD=1. Hold until memReady; retire in the memReady cycle; go to FETCH.
- EXEC: aluSrcA=1, aluSrcB=00. aluOp from funct:
  - 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111.
  - Any other funct → TRAP; no write occurs.
  - Otherwise go to RWB.
- RWB: regWrite=1, regDst=1, memToReg=0. Retire; go to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=sub, pcSource=01, branch=1. Retire; go to FETCH.
- JUMP: pcWrite=1, pcSource=10. Retire; go to FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=add; go to ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0. Retire; go to FETCH.
- TRAP: halted=1; every strobe is 0. TRAP is absorbing until reset.
- Outputs not listed for a state are 0.
- `retired` increments by 1 in each retire cycle and wraps modulo 2^RETIRE_W.

## Timing
- Reset, asynchronous: state=FETCH, retired=0, halted=0.
- While reset is high, all strobes are forced to 0: pcEn, irWrite, memRead, memWrite, regWrite.
- The first fetch strobe appears in the first cycle after reset deasserts.
- Outputs are Moore, decoded from state, except:
  - irWrite/pcEn in FETCH and the MEMWR retire are gated by memReady.
  - pcEn in BRANCH is gated by isZero.
- Latency with zero-wait memory (memReady tied high):
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
- Each wait cycle in FETCH/MEMRD/MEMWR adds exactly one cycle. Strobes stay stable throughout the wait.
- Reset asserted mid-instruction aborts the instruction at once. No partial retire.

## Test plan
- Reset with memReady=1: after reset release, state sequence is 0,1. pcEn=1 and irWrite=1 in the FETCH cycle; retired=0.
- Program add, lw, sw, beq (isZero=1), j, addi with memReady=1:
  - Visited state sequences match the Operation section.
  - Cycle counts are 4, 5, 4, 3, 3, 4.
  - retired=6 at the end.
- lw with memReady low for 3 cycles in both FETCH and MEMRD:
  - Instruction takes 11 cycles.
  - memRead stays high during the waits.
  - irWrite pulses exactly once.
- beq with isZero=0: pcEn=0 in BRANCH, retired still increments. Repeat with isZero=1: pcEn=1, pcSource=01.
- Opcode 111111, then R-type with funct 000000:
  - Each goes to TRAP with halted=1.
  - No regWrite/memWrite at any point.
  - Remains in TRAP for 20 cycles until reset.
- Reset pulse asserted in MEMWR while memReady=0:
  - Immediate state=FETCH with memWrite=0.
  - retired cleared to 0.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multi-cycle sequencer (master) and the MIPS datapath (slave).
// Instruction fields and status flow into the sequencer, and selects and strobes flow out.
interface multicycle_sequencer_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       isZero;
  logic       memReady;

  logic       pcEn;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       regDst;
  logic       memToReg;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [3:0] aluOp;
  logic [1:0] pcSource;

  modport master (
    input  opcode, funct, isZero, memReady,
    output pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg,
           regWrite, aluSrcA, aluSrcB, aluOp, pcSource
  );

  modport slave (
    output opcode, funct, isZero, memReady,
    input  pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg,
           regWrite, aluSrcA, aluSrcB, aluOp, pcSource
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control FSM: walks each instruction through fetch/decode/execute/memory/write-back,
// stalls on memReady, traps on unsupported encodings and counts retired instructions.
module multicycle_sequencer #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_sequencer_if.master bus,
  output logic [3:0]          state,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    TRAP   = 4'd12
  } stateT;

  typedef struct packed {
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [3:0] aluOp;
    logic [1:0] pcSource;
    logic       halted;
  } ctrlT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  stateT stateReg;
  stateT nextState;
  ctrlT  ctrl;
  logic  retireNow;

  function automatic logic functValid(logic [5:0] fn);
    case (fn)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] functAluOp(logic [5:0] fn);
    case (fn)
      6'b100000: return ALU_ADD;
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  function automatic stateT nextStateOf(stateT s, logic [5:0] op, logic [5:0] fn, logic ready);
    case (s)
      FETCH:  return ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_RTYPE:     return EXEC;
          OP_LW, OP_SW: return MEMADR;
          OP_BEQ:       return BRANCH;
          OP_J:         return JUMP;
          OP_ADDI:      return ADDIEX;
          default:      return TRAP;
        endcase
      end
      MEMADR: return (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  return ready ? MEMWB : MEMRD;
      MEMWR:  return ready ? FETCH : MEMWR;
      EXEC:   return functValid(fn) ? RWB : TRAP;
      ADDIEX: return ADDIWB;
      MEMWB, RWB, BRANCH, JUMP, ADDIWB: return FETCH;
      default: return TRAP;
    endcase
  endfunction

  // Moore control word for a state; EXEC also folds in the ALU op chosen by funct.
  function automatic ctrlT decodeCtrl(stateT s, logic [5:0] fn);
    ctrlT c;
    c = '0;
    case (s)
      FETCH:  begin c.memRead = 1'b1; c.aluSrcB = 2'b01; c.aluOp = ALU_ADD; end
      DECODE: begin c.aluSrcB = 2'b11; c.aluOp = ALU_ADD; end
      MEMADR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = ALU_ADD; end
      MEMRD:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
      MEMWB:  begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
      MEMWR:  begin c.memWrite = 1'b1; c.iorD = 1'b1; end
      EXEC:   begin c.aluSrcA = 1'b1; c.aluOp = functAluOp(fn); end
      RWB:    begin c.regWrite = 1'b1; c.regDst = 1'b1; end
      BRANCH: begin c.aluSrcA = 1'b1; c.aluOp = ALU_SUB; c.pcSource = 2'b01; end
      JUMP:   c.pcSource = 2'b10;
      ADDIEX: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = ALU_ADD; end
      ADDIWB: c.regWrite = 1'b1;
      TRAP:   c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nextState = nextStateOf(stateReg, bus.opcode, bus.funct, bus.memReady);
    case (stateReg)
      MEMWB, RWB, BRANCH, JUMP, ADDIWB: retireNow = 1'b1;
      MEMWR:                            retireNow = bus.memReady;
      default:                          retireNow = 1'b0;
    endcase
  end

  // The control word is registered from the next state so it lines up with stateReg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= FETCH;
      ctrl     <= decodeCtrl(FETCH, 6'b000000);
      retired  <= '0;
    end else begin
      stateReg <= nextState;
      ctrl     <= decodeCtrl(nextState, bus.funct);
      if (retireNow) retired <= retired + 1'b1;
    end
  end

  // Strobes are masked while reset is high so an abort never leaks a write.
  assign bus.memRead  = ctrl.memRead  & ~reset;
  assign bus.memWrite = ctrl.memWrite & ~reset;
  assign bus.regWrite = ctrl.regWrite & ~reset;
  assign bus.irWrite  = (stateReg == FETCH) & bus.memReady & ~reset;
  assign bus.pcEn     = ~reset & (((stateReg == FETCH) & bus.memReady) |
                                  (stateReg == JUMP) |
                                  ((stateReg == BRANCH) & bus.isZero));

  assign bus.iorD     = ctrl.iorD;
  assign bus.regDst   = ctrl.regDst;
  assign bus.memToReg = ctrl.memToReg;
  assign bus.aluSrcA  = ctrl.aluSrcA;
  assign bus.aluSrcB  = ctrl.aluSrcB;
  assign bus.aluOp    = ctrl.aluOp;
  assign bus.pcSource = ctrl.pcSource;

  assign state  = stateReg;
  assign halted = ctrl.halted;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: a per-instruction plan of expected states and memReady is built
// from the instruction class and wait counts, then the DUT is driven and checked cycle by cycle.
module tb_multicycle_sequencer;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXEC = 6, S_RWB = 7, S_BRANCH = 8, S_JUMP = 9,
                 S_ADDIEX = 10, S_ADDIWB = 11, S_TRAP = 12;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;

  typedef struct { int st; bit rdy; } cycT;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic        halted;
  logic [31:0] retired;

  multicycle_sequencer_if bus();

  multicycle_sequencer #(.RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state(state), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  cycT plan[$];
  int  checkCount = 0;
  int  passCount = 0;
  int  modelRetired = 0;
  int  lat;
  int  irPulses;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
  endtask

  // Reference ALU op for a funct; -1 marks an unsupported funct.
  function automatic int refAluOp(input logic [5:0] fn);
    case (fn)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  task automatic addWait(input int st, input int waits);
    for (int k = 0; k < waits; k++) plan.push_back('{st, 1'b0});
    plan.push_back('{st, 1'b1});
  endtask

  task automatic addFree(input int st);
    plan.push_back('{st, 1'($urandom)});
  endtask

  task automatic buildPlan(input logic [5:0] op, input logic [5:0] fn, input int wF, input int wM, input int trapHold);
    plan.delete();
    addWait(S_FETCH, wF);
    addFree(S_DECODE);
    case (op)
      OP_R: begin
        addFree(S_EXEC);
        if (refAluOp(fn) >= 0) addFree(S_RWB);
        else for (int k = 0; k < trapHold; k++) addFree(S_TRAP);
      end
      OP_LW:   begin addFree(S_MEMADR); addWait(S_MEMRD, wM); addFree(S_MEMWB); end
      OP_SW:   begin addFree(S_MEMADR); addWait(S_MEMWR, wM); end
      OP_BEQ:  addFree(S_BRANCH);
      OP_J:    addFree(S_JUMP);
      OP_ADDI: begin addFree(S_ADDIEX); addFree(S_ADDIWB); end
      default: for (int k = 0; k < trapHold; k++) addFree(S_TRAP);
    endcase
  endtask

  // Drives the current plan starting #1 after a rising edge, checks at each falling edge.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input bit z, input int limit,
                               output int cycles, output int pulses);
    bit leftFetch;
    int s;
    bit r;
    bit zz;
    cycles = 0;
    pulses = 0;
    leftFetch = 0;
    bus.opcode = op;
    bus.funct  = fn;
    for (int i = 0; i < plan.size() && i < limit; i++) begin
      s  = plan[i].st;
      r  = plan[i].rdy;
      zz = (s == S_BRANCH) ? z : 1'($urandom);
      bus.memReady = r;
      bus.isZero   = zz;
      @(negedge clk);
      checkOutput("state",    32'(state),        32'(s));
      checkOutput("memRead",  32'(bus.memRead),  32'(s == S_FETCH || s == S_MEMRD));
      checkOutput("memWrite", 32'(bus.memWrite), 32'(s == S_MEMWR));
      checkOutput("regWrite", 32'(bus.regWrite), 32'(s == S_MEMWB || s == S_RWB || s == S_ADDIWB));
      checkOutput("irWrite",  32'(bus.irWrite),  32'(s == S_FETCH && r));
      checkOutput("pcEn",     32'(bus.pcEn),     32'((s == S_FETCH && r) || s == S_JUMP || (s == S_BRANCH && zz)));
      checkOutput("halted",   32'(halted),       32'(s == S_TRAP));
      checkOutput("retired",  retired,           32'(modelRetired));
      case (s)
        S_FETCH:  begin checkOutput("fetchSrcB", 32'(bus.aluSrcB), 1); checkOutput("fetchIorD", 32'(bus.iorD), 0); end
        S_DECODE: begin checkOutput("decSrcB", 32'(bus.aluSrcB), 3); checkOutput("decAluOp", 32'(bus.aluOp), 2); end
        S_EXEC:   if (refAluOp(fn) >= 0) checkOutput("execAluOp", 32'(bus.aluOp), 32'(refAluOp(fn)));
        S_MEMRD, S_MEMWR: checkOutput("memIorD", 32'(bus.iorD), 1);
        S_MEMWB:  checkOutput("wbMemToReg", 32'(bus.memToReg), 1);
        S_RWB:    checkOutput("rwbRegDst", 32'(bus.regDst), 1);
        S_BRANCH: begin checkOutput("brPcSrc", 32'(bus.pcSource), 1); checkOutput("brAluOp", 32'(bus.aluOp), 6); end
        S_JUMP:   checkOutput("jPcSrc", 32'(bus.pcSource), 2);
        default: ;
      endcase
      if (state != 4'(S_FETCH)) leftFetch = 1;
      if (!leftFetch || state != 4'(S_FETCH)) cycles++;
      pulses += int'(bus.irWrite);
      if (s == S_MEMWB || s == S_RWB || s == S_BRANCH || s == S_JUMP || s == S_ADDIWB || (s == S_MEMWR && r))
        modelRetired++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input bit z, input int wF, input int wM,
                          output int cycles, output int pulses);
    buildPlan(op, fn, wF, wM, 21);
    applyStimulus(op, fn, z, 1000, cycles, pulses);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #1;
    checkOutput("rstState",   32'(state),        0);
    checkOutput("rstHalted",  32'(halted),       0);
    checkOutput("rstRetired", retired,           0);
    checkOutput("rstMemWr",   32'(bus.memWrite), 0);
    checkOutput("rstMemRd",   32'(bus.memRead),  0);
    modelRetired = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] fns[5];
    logic [5:0] op;
    logic [5:0] fn;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b1;
    bus.opcode = '0;
    bus.funct = '0;
    bus.isZero = 1'b0;
    bus.memReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetState",   32'(state),       0);
    checkOutput("resetRetired", retired,          0);
    checkOutput("resetIrWrite", 32'(bus.irWrite), 0);
    checkOutput("resetPcEn",    32'(bus.pcEn),    0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    runInstr(OP_R,    6'b100000, 1'b0, 0, 0, lat, irPulses); checkOutput("latAdd",  32'(lat), 4);
    runInstr(OP_LW,   6'b000000, 1'b0, 0, 0, lat, irPulses); checkOutput("latLw",   32'(lat), 5);
    runInstr(OP_SW,   6'b000000, 1'b0, 0, 0, lat, irPulses); checkOutput("latSw",   32'(lat), 4);
    runInstr(OP_BEQ,  6'b000000, 1'b1, 0, 0, lat, irPulses); checkOutput("latBeq",  32'(lat), 3);
    runInstr(OP_J,    6'b000000, 1'b0, 0, 0, lat, irPulses); checkOutput("latJ",    32'(lat), 3);
    runInstr(OP_ADDI, 6'b000000, 1'b0, 0, 0, lat, irPulses); checkOutput("latAddi", 32'(lat), 4);
    bus.memReady = 1'b0;
    @(negedge clk);
    checkOutput("retiredProg", retired, 6);
    @(posedge clk);
    #1;

    runInstr(OP_LW, 6'b000000, 1'b0, 3, 3, lat, irPulses);
    checkOutput("latLwWait", 32'(lat), 11);
    checkOutput("irPulses",  32'(irPulses), 1);

    runInstr(OP_BEQ, 6'b000000, 1'b0, 0, 0, lat, irPulses);
    runInstr(OP_BEQ, 6'b000000, 1'b1, 0, 0, lat, irPulses);

    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 5)];
      fn = fns[$urandom_range(0, 4)];
      runInstr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), lat, irPulses);
    end

    // Abort a store while it is stalled in MEMWR.
    buildPlan(OP_SW, 6'b000000, 0, 5, 0);
    applyStimulus(OP_SW, 6'b000000, 1'b0, 4, lat, irPulses);
    bus.memReady = 1'b0;
    #2;
    checkOutput("preAbortMemWr", 32'(bus.memWrite), 1);
    pulseReset();

    runInstr(6'b111111, 6'b000000, 1'b0, 0, 0, lat, irPulses);
    pulseReset();
    runInstr(OP_R, 6'b000000, 1'b0, 1, 0, lat, irPulses);
    pulseReset();
    runInstr(OP_ADDI, 6'b000000, 1'b0, 0, 0, lat, irPulses);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
